// File: rtl/ofifo.sv
// ofifo: per-column psum buffers that release aligned full rows to readout.
// Latency: a write on edge N is visible at out in cycle N+1 (first-word-fall-through).
// Backpressure: o_ready/o_full from pointers only; full-column writes drop unless a pop
// occurs in the same cycle, and a drop sets sticky o_ovf.
// Build option: define OFIFO_RELU_EN to clamp negative heads to zero at out.

// Single-column FIFO with extra-MSB pointers. The storage is not reset.
module ofifo_colfifo #(
  parameter int W     = 16,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;

  // Empty when the pointers match; full when only the wrap bit differs.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dat   = r_mem[r_rptr[AW-1:0]];

  // Storage write. When the column is full and popping, the write slot is
  // the slot being vacated, so the old head is read before it is replaced.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_dat;
    end
  end

  // Pointer update. Pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end
endmodule

module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);
  logic [col-1:0]     w_empty;
  logic [col-1:0]     w_col_full;
  logic [col-1:0]     w_push;
  logic [col-1:0]     w_drop;
  logic               w_pop;
  logic [psum_bw-1:0] w_head [col];
  logic               r_ovf;

  // Row-level flags come only from the pointer-derived column flags.
  assign o_valid = ~|w_empty;
  assign o_full  = |w_col_full;
  assign o_ready = ~o_full;
  assign o_ovf   = r_ovf;

  // A pop needs every column populated; rd without a full row is ignored.
  assign w_pop = rd & o_valid;

  // A pop in the same cycle frees a slot, so a full column can still accept.
  assign w_push = wr & (~w_col_full | {col{w_pop}});
  assign w_drop = wr & w_col_full & ~{col{w_pop}};

  for (genvar g = 0; g < col; g++) begin : g_col
    ofifo_colfifo #(
      .W     (psum_bw),
      .DEPTH (depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_pop   (w_pop),
      .i_dat   (in[psum_bw*g +: psum_bw]),
      .o_dat   (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_col_full[g])
    );

    logic [psum_bw-1:0] w_view;
`ifdef OFIFO_RELU_EN
    // Negative heads (two's complement) are presented as zero; storage keeps the raw value.
    assign w_view = w_head[g][psum_bw-1] ? '0 : w_head[g];
`else
    assign w_view = w_head[g];
`endif
    // Output is zeroed until a full row is available.
    assign out[psum_bw*g +: psum_bw] = o_valid ? w_view : '0;
  end

  // Sticky overflow: any dropped write sets it, only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ofifo.sv
module tb_ofifo;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;
  localparam int NV  = 11;

  logic             clk;
  logic             reset;
  logic [COL-1:0]   wr;
  logic [BW*COL-1:0] in;
  logic             rd;
  logic [BW*COL-1:0] out;
  logic             o_valid;
  logic             o_full;
  logic             o_ready;
  logic             o_ovf;

  int total = 0;
  int bad   = 0;

  logic [BW*COL-1:0] exp_q[$];
  logic              exp_ovf;

  typedef struct {
    logic [COL-1:0]    wr;
    logic [BW*COL-1:0] din;
    logic              rd;
    logic              ev;
    logic              ef;
    logic [BW*COL-1:0] eo;
  } vec_t;
  vec_t vt[NV];

  ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BW*COL-1:0] act, input logic [BW*COL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [BW*COL-1:0] mkrow(input int base);
    logic [BW*COL-1:0] r;
    for (int c = 0; c < COL; c++) r[BW*c +: BW] = 16'(base + c * 256);
    return r;
  endfunction

  function automatic logic [BW*COL-1:0] view(input logic [BW*COL-1:0] r);
    logic [BW*COL-1:0] v;
    v = r;
`ifdef OFIFO_RELU_EN
    for (int c = 0; c < COL; c++) if (r[BW*c + BW-1]) v[BW*c +: BW] = '0;
`endif
    return v;
  endfunction

  // One cycle with scoreboard bookkeeping; w is all-ones or zero.
  task automatic sb_cycle(input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
    logic popping;
    logic fullnow;
    wr = w; in = d; rd = r;
    popping = r && (exp_q.size() > 0);
    fullnow = (exp_q.size() == DEP);
    if (popping) begin
      chk("pop_head", out, view(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (w == '1) begin
      if (!fullnow || popping) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    wr = '0; rd = 1'b0;
    chk1("sb_valid", o_valid, exp_q.size() > 0);
    chk1("sb_full",  o_full,  exp_q.size() == DEP);
    chk1("sb_ready", o_ready, exp_q.size() != DEP);
    chk1("sb_ovf",   o_ovf,   exp_ovf);
    chk("sb_out", out, (exp_q.size() > 0) ? view(exp_q[0]) : '0);
  endtask

  initial begin
    logic [BW*COL-1:0] acc;
    logic [BW*COL-1:0] rl_in;
    logic [BW*COL-1:0] rl_out;

    // Skewed write: column i written on cycle i with value i+1.
    acc = '0;
    for (int i = 0; i < COL; i++) begin
      vt[i].wr  = COL'(1) << i;
      vt[i].din = '0;
      vt[i].din[BW*i +: BW] = 16'(i + 1);
      acc[BW*i +: BW] = 16'(i + 1);
      vt[i].rd  = 1'b0;
      vt[i].ev  = (i == COL-1);
      vt[i].ef  = 1'b0;
      vt[i].eo  = (i == COL-1) ? acc : '0;
    end
    vt[8] = '{wr: '0, din: '0, rd: 1'b1, ev: 1'b0, ef: 1'b0, eo: '0};
    // ReLU row: column 0 negative, column 1 positive.
    rl_in = '0;
    for (int c = 0; c < COL; c++) rl_in[BW*c +: BW] = 16'h0003;
    rl_in[BW*0 +: BW] = 16'hFFF6;
    rl_in[BW*1 +: BW] = 16'h000A;
    rl_out = rl_in;
`ifdef OFIFO_RELU_EN
    rl_out[BW*0 +: BW] = 16'h0000;
`endif
    vt[9]  = '{wr: '1, din: rl_in, rd: 1'b0, ev: 1'b1, ef: 1'b0, eo: rl_out};
    vt[10] = '{wr: '0, din: '0, rd: 1'b1, ev: 1'b0, ef: 1'b0, eo: '0};

    // Reset state.
    reset = 1'b0; wr = '0; in = '0; rd = 1'b0; exp_ovf = 1'b0;
    #1;
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_full",  o_full,  1'b0);
    chk1("rst_ready", o_ready, 1'b1);
    chk1("rst_ovf",   o_ovf,   1'b0);
    chk("rst_out", out, '0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    // Table vectors: drive, clock, check post-edge outputs.
    for (int k = 0; k < NV; k++) begin
      wr = vt[k].wr; in = vt[k].din; rd = vt[k].rd;
      @(posedge clk); #1;
      wr = '0; rd = 1'b0;
      chk1($sformatf("vec%0d_valid", k), o_valid, vt[k].ev);
      chk1($sformatf("vec%0d_full", k),  o_full,  vt[k].ef);
      chk1($sformatf("vec%0d_ovf", k),   o_ovf,   1'b0);
      chk($sformatf("vec%0d_out", k), out, vt[k].eo);
    end

    // Fill to full with 64 rows.
    for (int k = 0; k < DEP; k++) sb_cycle('1, mkrow(k), 1'b0);
    chk1("fill_full",  o_full,  1'b1);
    chk1("fill_ready", o_ready, 1'b0);
    // Full with simultaneous write and pop: accepted, no overflow.
    sb_cycle('1, mkrow(100), 1'b1);
    chk1("fullwp_ovf", o_ovf, 1'b0);
    // Write while full and no pop: dropped, sticky overflow.
    sb_cycle('1, mkrow(999), 1'b0);
    chk1("drop_ovf", o_ovf, 1'b1);
    // Drain everything in order, then rd on empty is ignored.
    for (int k = 0; k < DEP; k++) sb_cycle('0, '0, 1'b1);
    sb_cycle('0, '0, 1'b1);

    // Reset mid-operation discards buffered rows and clears overflow.
    sb_cycle('1, mkrow(7), 1'b0);
    sb_cycle('1, mkrow(8), 1'b0);
    #3 reset = 1'b0;
    #1;
    chk1("mrst_valid", o_valid, 1'b0);
    chk1("mrst_full",  o_full,  1'b0);
    chk1("mrst_ready", o_ready, 1'b1);
    chk1("mrst_ovf",   o_ovf,   1'b0);
    chk("mrst_out", out, '0);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Pointer wrap: 200 rows streamed at occupancy 3.
    for (int k = 0; k < 3; k++) sb_cycle('1, mkrow(k), 1'b0);
    for (int k = 3; k < 200; k++) sb_cycle('1, mkrow(k), 1'b1);
    for (int k = 0; k < 3; k++) sb_cycle('0, '0, 1'b1);
    chk1("wrap_empty", o_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
